osc_clock_sequencer: RTL and testbench

Sits directly downstream of the internal-oscillator clock (15.625 MHz, oscillator divide-by-16). Turns that free-running clock into a clean synchronous system reset, gated on reset stretching plus a filtered PLL-lock input. Once running, it generates the fractional-rate CPU clock-enable (nominally 3.5 MHz) and a 1 kHz housekeeping tick. All ZX Spectrum core logic clocked from the oscillator consumes these instead of deriving its own enables.

---
 rtl/osc_clock_sequencer.sv | 122 ++++++++++++
 tb/tb_osc_clock_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/osc_clock_sequencer.sv
// osc_clock_sequencer
// Turns the free-running oscillator clock into a stretched, lock-qualified
// synchronous system reset, then produces the fractional-rate CPU clock
// enable and a 1 kHz housekeeping tick for the core logic.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_HOLD      | reset stretch, counts RST_CYCLES edges, sys_rst held high
// ST_WAIT_LOCK | waits for LOCK_CYCLES consecutive pll_lock highs
// ST_RUN       | sys_rst low, cpu_ce and ms_tick generators active
module osc_clock_sequencer #(
  parameter int ACC_W       = 24,
  parameter int CPU_INC     = 3758096,
  parameter int MS_DIV      = 15625,
  parameter int RST_CYCLES  = 1024,
  parameter int LOCK_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_lock,
  input  logic ce_enable,
  output logic sys_rst,
  output logic locked,
  output logic cpu_ce,
  output logic ms_tick
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int MS_W   = $clog2(MS_DIV);

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    acc_sum;
  logic [MS_W-1:0]   ms_cnt;
  logic              hold_done;
  logic              lock_done;
  logic              ms_wrap;
  logic              run_stay;
  logic              sys_rst_nxt;

  assign hold_done = (hold_cnt == HOLD_W'(RST_CYCLES - 1));
  assign lock_done = (lock_cnt == LOCK_W'(LOCK_CYCLES - 1));
  assign ms_wrap   = (ms_cnt == MS_W'(MS_DIV - 1));
  assign acc_sum   = {1'b0, acc} + (ACC_W + 1)'(CPU_INC);

  // State register; reset always restarts the full power-up sequence
  always_ff @(posedge clk) begin
    if (reset) state <= ST_HOLD;
    else       state <= state_nxt;
  end

  // Next-state decode; lock loss in RUN falls back to WAIT_LOCK, never HOLD
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD:      if (hold_done) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (pll_lock && lock_done) state_nxt = ST_RUN;
      ST_RUN:       if (!pll_lock) state_nxt = ST_WAIT_LOCK;
      default:      state_nxt = ST_HOLD;
    endcase
  end

  // Output decode: generators only advance when RUN is kept across this edge,
  // so pulses stop on the same edge sys_rst rises
  always_comb begin
    run_stay    = !reset && (state == ST_RUN) && (state_nxt == ST_RUN);
    sys_rst_nxt = reset || (state_nxt != ST_RUN);
  end

  // Registered reset / lock status outputs
  always_ff @(posedge clk) begin
    sys_rst <= sys_rst_nxt;
    locked  <= !sys_rst_nxt;
  end

  // Reset-stretch counter, only advances in HOLD
  always_ff @(posedge clk) begin
    if (reset)                              hold_cnt <= '0;
    else if (state == ST_HOLD && !hold_done) hold_cnt <= hold_cnt + 1'b1;
  end

  // Consecutive-lock counter; any low sample restarts the qualification
  always_ff @(posedge clk) begin
    if (reset || state != ST_WAIT_LOCK || !pll_lock || lock_done) lock_cnt <= '0;
    else                                                         lock_cnt <= lock_cnt + 1'b1;
  end

  // Phase accumulator: frozen while paused, cleared whenever RUN is left
  always_ff @(posedge clk) begin
    if (!run_stay) begin
      acc    <= '0;
      cpu_ce <= 1'b0;
    end else if (ce_enable) begin
      acc    <= acc_sum[ACC_W-1:0];
      cpu_ce <= acc_sum[ACC_W];
    end else begin
      cpu_ce <= 1'b0;
    end
  end

  // Millisecond divider, independent of ce_enable
  always_ff @(posedge clk) begin
    if (!run_stay) begin
      ms_cnt  <= '0;
      ms_tick <= 1'b0;
    end else begin
      ms_cnt  <= ms_wrap ? '0 : ms_cnt + 1'b1;
      ms_tick <= ms_wrap;
    end
  end

endmodule

// File: tb/tb_osc_clock_sequencer.sv
// Testbench for osc_clock_sequencer: two instances (default rates and a
// small fast configuration) share one stimulus stream; a reference model
// predicts every output per edge into a scoreboard queue.
module tb_osc_clock_sequencer;

  logic clk;
  logic reset;
  logic pll_lock;
  logic ce_enable;
  logic sys_rst_b, locked_b, cpu_ce_b, ms_tick_b;
  logic sys_rst_s, locked_s, cpu_ce_s, ms_tick_s;

  int n_cmp = 0;
  int n_bad = 0;

  osc_clock_sequencer dut_big (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .ce_enable(ce_enable),
    .sys_rst(sys_rst_b), .locked(locked_b), .cpu_ce(cpu_ce_b), .ms_tick(ms_tick_b)
  );

  osc_clock_sequencer #(
    .ACC_W(8), .CPU_INC(64), .MS_DIV(5), .RST_CYCLES(3), .LOCK_CYCLES(2)
  ) dut_small (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .ce_enable(ce_enable),
    .sys_rst(sys_rst_s), .locked(locked_s), .cpu_ce(cpu_ce_s), .ms_tick(ms_tick_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int w; longint inc; longint msdiv; int rstc; int lockc;
  } prm_t;

  typedef struct {
    int since_rel; bit in_run; int streak; longint n; longint rc;
  } mdl_t;

  prm_t pb = '{w: 24, inc: 3758096, msdiv: 15625, rstc: 1024, lockc: 256};
  prm_t ps = '{w: 8, inc: 64, msdiv: 5, rstc: 3, lockc: 2};
  mdl_t mb = '{0, 1'b0, 0, 0, 0};
  mdl_t msm = '{0, 1'b0, 0, 0, 0};

  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: n = enabled RUN cycles, pulse when floor(n*inc/2^w) steps;
  // ms tick when RUN cycle count is a multiple of the divider.
  // Output vector is {sys_rst, locked, cpu_ce, ms_tick}.
  task automatic mstep(input prm_t p, input mdl_t si, input bit r, input bit l, input bit c,
                       output mdl_t so, output logic [3:0] o);
    bit cpu, tick;
    so = si;
    o = 4'b1000;
    cpu = 1'b0;
    tick = 1'b0;
    if (r) begin
      so.since_rel = 0; so.in_run = 1'b0; so.streak = 0; so.n = 0; so.rc = 0;
    end else if (so.since_rel < p.rstc) begin
      so.since_rel++;
    end else if (so.in_run) begin
      if (!l) begin
        so.in_run = 1'b0; so.streak = 0;
      end else begin
        so.rc++;
        if (c) begin
          so.n++;
          cpu = ((so.n * p.inc) >> p.w) != (((so.n - 1) * p.inc) >> p.w);
        end
        tick = (so.rc % p.msdiv) == 0;
        o = {1'b0, 1'b1, cpu, tick};
      end
    end else begin
      so.streak = l ? so.streak + 1 : 0;
      if (so.streak == p.lockc) begin
        so.in_run = 1'b1; so.n = 0; so.rc = 0;
        o = 4'b0100;
      end
    end
  endtask

  task automatic step(input bit r, input bit l, input bit c);
    logic [3:0] ob, os;
    reset = r; pll_lock = l; ce_enable = c;
    mstep(pb, mb, r, l, c, mb, ob);
    mstep(ps, msm, r, l, c, msm, os);
    exp_q.push_back({ob, os});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per edge and compares both instances
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("big_sys_rst", {31'd0, sys_rst_b}, {31'd0, e[7]});
        chk("big_locked",  {31'd0, locked_b},  {31'd0, e[6]});
        chk("big_cpu_ce",  {31'd0, cpu_ce_b},  {31'd0, e[5]});
        chk("big_ms_tick", {31'd0, ms_tick_b}, {31'd0, e[4]});
        chk("sm_sys_rst",  {31'd0, sys_rst_s}, {31'd0, e[3]});
        chk("sm_locked",   {31'd0, locked_s},  {31'd0, e[2]});
        chk("sm_cpu_ce",   {31'd0, cpu_ce_s},  {31'd0, e[1]});
        chk("sm_ms_tick",  {31'd0, ms_tick_s}, {31'd0, e[0]});
      end
    end
  end

  task automatic powerup_seq(input string tag);
    for (int k = 1; k <= 1300; k++) begin
      step(1'b0, 1'b1, 1'b1);
      if (k == 1279) chk({tag, "_sysrst_1279"}, {31'd0, sys_rst_b}, 32'd1);
      if (k == 1280) begin
        chk({tag, "_sysrst_1280"}, {31'd0, sys_rst_b}, 32'd0);
        chk({tag, "_locked_1280"}, {31'd0, locked_b}, 32'd1);
      end
    end
  endtask

  initial begin
    int cnt_cpu, cnt_ms;
    reset = 1'b1; pll_lock = 1'b1; ce_enable = 1'b1;

    // power-up
    repeat (4) step(1'b1, 1'b1, 1'b1);
    chk("reset_sysrst", {31'd0, sys_rst_b}, 32'd1);
    chk("reset_locked", {31'd0, locked_b}, 32'd0);
    powerup_seq("pwrup");

    // lock glitch during WAIT_LOCK at edge 1100
    step(1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 1400; k++) begin
      step(1'b0, k != 1100, 1'b1);
      if (k == 1355) chk("glitch_sysrst_1355", {31'd0, sys_rst_b}, 32'd1);
      if (k == 1356) chk("glitch_sysrst_1356", {31'd0, sys_rst_b}, 32'd0);
    end

    // rate window: 15625 enabled RUN cycles
    cnt_cpu = 0; cnt_ms = 0;
    repeat (15625) begin
      step(1'b0, 1'b1, 1'b1);
      cnt_cpu += int'(cpu_ce_b);
      cnt_ms  += int'(ms_tick_b);
    end
    n_cmp++;
    if (cnt_cpu != 3500 && cnt_cpu != 3501) begin
      n_bad++;
      $display("FAIL cpu_rate: got %0d pulses want 3500 or 3501", cnt_cpu);
    end
    chk("ms_rate", cnt_ms, 32'd1);

    // pause for 37 cycles
    cnt_cpu = 0;
    repeat (37) begin
      step(1'b0, 1'b1, 1'b0);
      cnt_cpu += int'(cpu_ce_b);
    end
    chk("pause_no_ce", cnt_cpu, 32'd0);

    // random ce and rare lock drops
    repeat (6000) step(1'b0, $urandom_range(0, 2999) != 0, $urandom_range(0, 3) != 0);

    // guaranteed RUN, then directed lock loss and relock
    repeat (300) step(1'b0, 1'b1, $urandom_range(0, 1) == 1);
    chk("pre_loss_locked", {31'd0, locked_b}, 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("loss_sysrst", {31'd0, sys_rst_b}, 32'd1);
    chk("loss_locked", {31'd0, locked_b}, 32'd0);
    chk("loss_cpu_ce", {31'd0, cpu_ce_b}, 32'd0);
    for (int k = 1; k <= 256; k++) begin
      step(1'b0, 1'b1, 1'b1);
      if (k == 255) chk("relock_255", {31'd0, locked_b}, 32'd0);
      if (k == 256) chk("relock_256", {31'd0, locked_b}, 32'd1);
    end

    // mid-run reset for one cycle
    repeat (100) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("midrst_sysrst", {31'd0, sys_rst_b}, 32'd1);
    chk("midrst_cpu_ce", {31'd0, cpu_ce_b}, 32'd0);
    chk("midrst_ms_tick", {31'd0, ms_tick_b}, 32'd0);
    powerup_seq("rerun");

    // long randomized run to cover several ms ticks and pauses
    repeat (20000) step(1'b0, 1'b1, $urandom_range(0, 4) != 0);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
